booth_product_serializer: RTL
=============================

Name: booth_product_serializer

Overview:
- Parallel-in/serial-out reader for the Booth multiplier's result path.
- The datapath loads the finished product word in one cycle. This block then shifts it out one bit per accepted transfer over a valid/ready serial interface.
- It flags the last bit and pulses done when the word has been fully delivered.
- It is the consumer end of the product register's parallel load interface.

Parameters:
- WIDTH, 16, product word width in bits (legal range 2..64).
- MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- ld, input, 1, load strobe; captures din when the block can accept.
- din, input, WIDTH, parallel product word.
- sout_ready, input, 1, downstream ready for the current serial bit.
- sout, output, 1, current serial data bit.
- sout_valid, output, 1, sout holds a valid bit.
- sout_last, output, 1, current bit is the final bit of the frame.
- busy, output, 1, a frame is in progress (SHIFT or PAR state).
- done, output, 1, one-cycle pulse after the final bit transfers.
- ld_err, output, 1, one-cycle pulse when ld arrives while busy.

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset: state=IDLE, shift register=0, bit counter=0.
  - All outputs are 0 on the cycle after reset is sampled high.
  - reset asserted mid-frame aborts the frame with no done pulse.
- States:
  - IDLE: idle, no frame.
  - SHIFT: data bits being sent.
  - PAR: parity bit; exists only with the optional feature.
  - DONE: one cycle, asserts done.
- Load acceptance: ld is accepted in IDLE or DONE (back-to-back frames allowed).
  - On accept, din is captured into the shift register, the counter is cleared, and the next state is SHIFT.
  - Latency: ld sampled at edge N gives sout_valid=1 with bit 0 after edge N.
- ld in SHIFT or PAR is ignored: frame contents are unchanged and ld_err pulses for 1 cycle.
- SHIFT:
  - sout_valid=1 and busy=1.
  - sout = shift register bit 0 (MSB_FIRST=0) or bit WIDTH-1 (MSB_FIRST=1).
  - sout is driven directly from a register bit (no combinational logic from inputs).
- Transfer: a bit transfers on an edge where sout_valid && sout_ready.
  - On transfer, shift by 1 (zero fill) and increment the counter.
  - When sout_ready=0, sout, sout_valid and sout_last hold stable. The block never withdraws valid.
- Frame end: sout_last=1 while counter==WIDTH-1 in SHIFT.
  - A transfer at that point moves to DONE (or to PAR with the feature enabled).
- DONE: done=1, busy=0, sout_valid=0 for exactly one cycle, then IDLE (or SHIFT if ld is accepted).
- Throughput: with sout_ready held high, a frame occupies exactly WIDTH cycles, plus 1 DONE cycle.
- Counter: width clog2(WIDTH+1); it never wraps within a frame.
- Simultaneous events: reset has priority over ld. In DONE, ld wins over the return to IDLE.

Optional Feature:
- Macro: BOOTH_SER_PARITY_EN.
- Defined: parity is captured at load as the XOR of all din bits (even parity).
  - After the last data bit transfers, the block enters PAR and drives sout=parity, sout_valid=1, sout_last=1.
  - sout_last is not asserted on the final data bit.
  - The frame is WIDTH+1 bits; DONE follows the parity transfer. PAR obeys the same stall rules as SHIFT.
- Undefined: the PAR state and parity register are absent, and the frame is WIDTH bits.

Test Plan:
- Basic LSB-first frame: WIDTH=16, MSB_FIRST=0, din=16'hA5C3, ld pulse, sout_ready=1.
  - sout sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - sout_last only on the 16th bit; done pulses at cycle 17 after ld.
- Backpressure: same word, sout_ready toggled 1,0,0,1,...
  - sout/sout_valid/sout_last stable across stalled cycles; the bit sequence is unchanged; done only after the 16th accepted bit.
- Load while busy: ld with din=16'hFFFF during bit 5 of a 16'h0000 frame.
  - ld_err=1 for one cycle; all 16 bits remain 0.
- Back-to-back frames: ld with din=16'h8001 asserted in the DONE cycle of the previous frame.
  - SHIFT on the next cycle with bit 0 = 1; no IDLE cycle in between.
- Reset mid-frame: reset at bit 7 of 16'hA5C3.
  - Next cycle all outputs 0, state IDLE, no done pulse; a new ld of 16'h0003 then gives 1,1,0,... normally.
- Parity build (macro defined): din=16'h0001 gives 17 bits, last bit = 1 with sout_last=1.
  - din=16'hA5C3 gives parity bit 0.

Source files
------------

// File: rtl/booth_product_serializer.sv
// Parallel-in/serial-out reader for the Booth multiplier product word, valid/ready serial side.
// Define BOOTH_SER_PARITY_EN to append an even-parity bit after the data bits.
module booth_product_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             sout_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy,
  output logic             done,
  output logic             ld_err
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam int            OUT_BIT    = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_shifted;
  logic [CW-1:0]    cnt;
`ifdef BOOTH_SER_PARITY_EN
  logic             parity;
`endif

  // The output bit is always a flop, so sout has no path from any input.
  assign sout       = sr[OUT_BIT];
  assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so sout reads 0 after reset instead of stale data.
      state      <= S_IDLE;
      sr         <= '0;
      cnt        <= '0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ld_err     <= 1'b0;
`ifdef BOOTH_SER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here; later non-blocking writes in this block override them.
      done   <= 1'b0;
      ld_err <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (ld) begin
            state      <= S_SHIFT;
            sr         <= din;
            cnt        <= '0;
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            busy       <= 1'b1;
`ifdef BOOTH_SER_PARITY_EN
            parity     <= ^din;
`endif
          end else begin
            state      <= S_IDLE;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
          end
        end

        S_SHIFT: begin
          ld_err <= ld;
          if (sout_ready) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST_IDX) begin
`ifdef BOOTH_SER_PARITY_EN
              // The parity bit is shifted into the output position so sout stays a register bit.
              state     <= S_PAR;
              sr        <= sr_shifted | (WIDTH'(parity) << OUT_BIT);
              sout_last <= 1'b1;
`else
              state      <= S_DONE;
              sr         <= sr_shifted;
              done       <= 1'b1;
              sout_valid <= 1'b0;
              sout_last  <= 1'b0;
              busy       <= 1'b0;
`endif
            end else begin
              sr <= sr_shifted;
`ifndef BOOTH_SER_PARITY_EN
              sout_last <= (cnt == PENULT_IDX);
`endif
            end
          end
        end

`ifdef BOOTH_SER_PARITY_EN
        S_PAR: begin
          ld_err <= ld;
          if (sout_ready) begin
            state      <= S_DONE;
            sr         <= sr_shifted;
            done       <= 1'b1;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          sout_valid <= 1'b0;
          sout_last  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
